pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-sequencing controller that drives the program counter's increment/load controls for the single-issue 16-bit processor. Fetches a 16-bit instruction from instruction memory over a req/ready handshake, decodes control-flow opcodes locally (jump, jump-if-zero, loop counter), and hands every other opcode to the datapath over a start/done handshake. Sits between instruction memory, the PC register and the execute datapath.

## Interface
- PC_W, 16, width of PC and jump target (target = zero-extended 12-bit immediate)
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin execution; sampled only in IDLE
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid on instr this cycle
- instr  in  16  instruction word; opcode = instr[15:12], imm = instr[11:0]
- Z  in  1  datapath zero flag, sampled in DECODE
- pc_inc  out  1  PC += 1 at next edge
- pc_load  out  1  PC <= pc_target at next edge
- pc_target  out  PC_W  {zeros, ir[11:0]}
- ir  out  16  latched instruction register
- exec_start  out  1  one-cycle pulse: datapath executes ir
- exec_done  in  1  datapath finished current instruction
- loop_cnt  out  12  loop counter value
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4
- halted  out  1  high iff state==HALT

## Operation
- Opcodes: 0xF HALT, 0xA JMP, 0xB JZ, 0xC LDC (load loop counter), 0xD DJNZ (decrement-and-jump-if-nonzero); all others (incl. 0x0) go to datapath.
- IDLE: outputs low. start=1 -> FETCH.
- FETCH: imem_req=1, held until imem_ready=1; on that edge ir <= instr, -> DECODE. imem_req falls the cycle after ready.
- DECODE (exactly one cycle), outputs combinational from ir/Z/loop_cnt:
  - HALT -> HALT; no pc_inc/pc_load.
  - JMP -> pc_load=1 -> FETCH.
  - JZ -> Z=1: pc_load=1; Z=0: pc_inc=1; -> FETCH.
  - LDC -> loop_cnt <= imm, pc_inc=1 -> FETCH.
  - DJNZ -> loop_cnt <= loop_cnt-1 (mod 2^12); if result != 0 pc_load=1 else pc_inc=1; -> FETCH. loop_cnt=0 wraps to 0xFFF and jumps.
  - other -> EXEC.
- EXEC: exec_start=1 in first EXEC cycle only. exec_done sampled every EXEC cycle incl. the first; on exec_done=1: pc_inc=1, -> FETCH. Waits indefinitely otherwise.
- HALT: terminal; only Reset exits. start ignored.
- pc_inc and pc_load never both high. Neither is asserted outside DECODE/EXEC.
- exec_done outside EXEC, imem_ready outside FETCH, start outside IDLE: ignored.

## Timing
- Reset (async, any state): state=IDLE, ir=0, loop_cnt=0, imem_req=0, exec_start=0, pc_inc=0, pc_load=0, halted=0, pc_target=0.
- Reset mid-fetch or mid-exec aborts; no pc_inc/pc_load issued; release requires start again.
- Control-flow instruction with imem_ready immediate: 2 cycles (FETCH, DECODE). Each extra wait cycle of imem_ready adds 1.
- Datapath instruction: FETCH + DECODE + N EXEC cycles, N>=1 (N=1 if exec_done high in first EXEC cycle).
- PC update lands on the edge ending DECODE/EXEC, so the following FETCH presents the new PC to memory.
- Z and loop_cnt used in DECODE are the values present during that cycle; loop_cnt update and PC load occur on the same edge.

## Test plan
- Reset then start, program {0x1000 (ALU), 0xF000}, imem_ready always 1, exec_done on first EXEC cycle -> states 1,2,3,1,2,4; exactly one exec_start pulse; one pc_inc; halted=1 and stays with start toggling.
- JZ 0x0B: instr 0xB00B with Z=1 -> pc_load=1, pc_target=0x000B in DECODE; repeat with Z=0 -> pc_inc=1, pc_load=0.
- Loop: LDC 3 (0xC003), then DJNZ 0x005 (0xD005) executed three times -> loop_cnt 3,2,1,0; pc_load on first two DJNZ, pc_inc on third; DJNZ with loop_cnt=0 -> loop_cnt=0xFFF, pc_load=1.
- Fetch stall: imem_ready low 4 cycles -> imem_req high 5 cycles, ir unchanged until ready edge, ir=instr after.
- Exec stall: exec_done low 6 cycles -> exec_start high only first EXEC cycle, no pc_inc until done; spurious exec_done in FETCH ignored.
- Async Reset asserted mid-EXEC (between clock edges) -> all outputs 0 immediately, state=IDLE, loop_cnt=0; no pc_inc on next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Instruction-sequencing controller for the single-issue
//                16-bit processor. Fetches an instruction over a req/ready
//                handshake and latches it into ir. Jump, jump-if-zero and
//                the loop-counter opcodes are decoded and resolved here.
//                Every other opcode goes to the datapath over a
//                start/done handshake. Drives the PC increment/load
//                controls so that the next FETCH presents the new PC.
//  Ports       : Clk, Reset      - clock (rising edge), async active-high reset
//                start           - begin execution (sampled in IDLE only)
//                imem_req/ready  - instruction fetch handshake, instr = word
//                Z               - datapath zero flag (used by JZ in DECODE)
//                pc_inc/pc_load  - PC controls, pc_target = zero-extended imm
//                ir              - latched instruction register
//                exec_start/done - datapath handshake
//                loop_cnt        - 12-bit loop counter (LDC / DJNZ)
//                state, halted   - FSM state and HALT indication
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int PC_W = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [15:0]     instr,
    input  logic            Z,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_target,
    output logic [15:0]     ir,
    output logic            exec_start,
    input  logic            exec_done,
    output logic [11:0]     loop_cnt,
    output logic [2:0]      state,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_JMP  = 4'hA;
    localparam logic [3:0] c_OP_JZ   = 4'hB;
    localparam logic [3:0] c_OP_LDC  = 4'hC;
    localparam logic [3:0] c_OP_DJNZ = 4'hD;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;
    logic [11:0] r_loop_cnt;
    logic        r_exec_first;

    logic        w_imem_req;
    logic        w_pc_inc;
    logic        w_pc_load;
    logic        w_exec_start;
    logic        w_loop_we;
    logic [11:0] w_loop_val;
    logic [11:0] w_loop_dec;
    logic [3:0]  w_opcode;

    assign w_opcode   = r_ir[15:12];
    // Modulo-4096 decrement: zero wraps to 0xFFF, which is nonzero and jumps.
    assign w_loop_dec = r_loop_cnt - 12'd1;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_imem_req   = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_load    = 1'b0;
        w_exec_start = 1'b0;
        w_loop_we    = 1'b0;
        w_loop_val   = r_loop_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end

            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                w_next_state = S_FETCH;
                case (w_opcode)
                    c_OP_HALT: begin
                        w_next_state = S_HALT;
                    end
                    c_OP_JMP: begin
                        w_pc_load = 1'b1;
                    end
                    c_OP_JZ: begin
                        w_pc_load = Z;
                        w_pc_inc  = ~Z;
                    end
                    c_OP_LDC: begin
                        w_loop_we  = 1'b1;
                        w_loop_val = r_ir[11:0];
                        w_pc_inc   = 1'b1;
                    end
                    c_OP_DJNZ: begin
                        w_loop_we  = 1'b1;
                        w_loop_val = w_loop_dec;
                        w_pc_load  = (w_loop_dec != 12'd0);
                        w_pc_inc   = (w_loop_dec == 12'd0);
                    end
                    default: begin
                        w_next_state = S_EXEC;
                    end
                endcase
            end

            S_EXEC: begin
                // exec_done is honoured even in the cycle exec_start pulses.
                w_exec_start = r_exec_first;
                if (exec_done) begin
                    w_pc_inc     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_ir         <= 16'h0000;
            r_loop_cnt   <= 12'h000;
            r_exec_first <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_FETCH) && imem_ready) begin
                r_ir <= instr;
            end
            if (w_loop_we) begin
                r_loop_cnt <= w_loop_val;
            end
            // EXEC is only ever entered from DECODE, so this marks its first cycle.
            r_exec_first <= (r_state == S_DECODE);
        end
    end

    assign imem_req   = w_imem_req;
    assign pc_inc     = w_pc_inc;
    assign pc_load    = w_pc_load;
    assign exec_start = w_exec_start;
    assign pc_target  = {{(PC_W-12){1'b0}}, r_ir[11:0]};
    assign ir         = r_ir;
    assign loop_cnt   = r_loop_cnt;
    assign state      = r_state;
    assign halted     = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking testbench for pc_sequencer.
//                Inputs change 1 time unit after a falling edge; outputs
//                are sampled at that same point, mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_W = 16;

    logic            Clk;
    logic            Reset;
    logic            start;
    logic            imem_req;
    logic            imem_ready;
    logic [15:0]     instr;
    logic            Z;
    logic            pc_inc;
    logic            pc_load;
    logic [PC_W-1:0] pc_target;
    logic [15:0]     ir;
    logic            exec_start;
    logic            exec_done;
    logic [11:0]     loop_cnt;
    logic [2:0]      state;
    logic            halted;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.PC_W(PC_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .instr      (instr),
        .Z          (Z),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .ir         (ir),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .loop_cnt   (loop_cnt),
        .state      (state),
        .halted     (halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to the middle of the next cycle.
    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    // Reset pulse driven between clock edges; leaves the DUT in IDLE.
    task automatic do_reset();
        Reset      = 1'b1;
        start      = 1'b0;
        imem_ready = 1'b0;
        exec_done  = 1'b0;
        Z          = 1'b0;
        instr      = 16'h0000;
        step();
        Reset = 1'b0;
    endtask

    // From IDLE: pulse start, return in the first FETCH cycle.
    task automatic go_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // From FETCH: present w with ready, return in the DECODE cycle.
    task automatic fetch_word(input logic [15:0] w);
        instr      = w;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset      = 1'b1;
        start      = 1'b0;
        imem_ready = 1'b0;
        exec_done  = 1'b0;
        Z          = 1'b0;
        instr      = 16'h0000;
        step();
        step();
        n_tests++;
        if (state !== 3'd0 || ir !== 16'h0 || loop_cnt !== 12'h0 || imem_req !== 1'b0 ||
            exec_start !== 1'b0 || pc_inc !== 1'b0 || pc_load !== 1'b0 || halted !== 1'b0 ||
            pc_target !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d ir=%h loop=%h req=%b es=%b inc=%b ld=%b h=%b tgt=%h, expected all zero",
                     state, ir, loop_cnt, imem_req, exec_start, pc_inc, pc_load, halted, pc_target);
        end
        Reset = 1'b0;
        step();
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_without_start: state=%0d expected 0", state);
        end
    endtask

    task automatic test_program();
        logic [2:0] exp_st [6];
        int es_cnt;
        int inc_cnt;
        int ld_cnt;
        exp_st = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd4};
        es_cnt = 0; inc_cnt = 0; ld_cnt = 0;
        imem_ready = 1'b1;
        start = 1'b1;
        step();                     // now in FETCH
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            instr     = (i < 3) ? 16'h1000 : 16'hF000;
            exec_done = (i == 2);
            #1;
            n_tests++;
            if (state !== exp_st[i]) begin
                n_fail++;
                $display("FAIL prog_state[%0d]: state=%0d expected %0d", i, state, exp_st[i]);
            end
            if (exec_start === 1'b1) es_cnt++;
            if (pc_inc === 1'b1) inc_cnt++;
            if (pc_load === 1'b1) ld_cnt++;
            step();
        end
        exec_done  = 1'b0;
        imem_ready = 1'b0;
        n_tests++;
        if (es_cnt != 1 || inc_cnt != 1 || ld_cnt != 0) begin
            n_fail++;
            $display("FAIL prog_pulses: exec_start=%0d pc_inc=%0d pc_load=%0d expected 1 1 0", es_cnt, inc_cnt, ld_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            step();
            n_tests++;
            if (state !== 3'd4 || halted !== 1'b1 || pc_inc !== 1'b0 || pc_load !== 1'b0 || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_sticky[%0d]: state=%0d halted=%b inc=%b ld=%b req=%b expected 4 1 0 0 0",
                         i, state, halted, pc_inc, pc_load, imem_req);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_jz();
        do_reset();
        go_start();
        Z = 1'b1;
        fetch_word(16'hB00B);
        n_tests++;
        if (state !== 3'd2 || pc_load !== 1'b1 || pc_inc !== 1'b0 || pc_target !== 16'h000B) begin
            n_fail++;
            $display("FAIL jz_taken: state=%0d ld=%b inc=%b tgt=%h expected 2 1 0 000b", state, pc_load, pc_inc, pc_target);
        end
        step();
        n_tests++;
        if (state !== 3'd1 || pc_load !== 1'b0) begin
            n_fail++;
            $display("FAIL jz_back_to_fetch: state=%0d ld=%b expected 1 0", state, pc_load);
        end
        Z = 1'b0;
        fetch_word(16'hB00B);
        n_tests++;
        if (pc_load !== 1'b0 || pc_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL jz_not_taken: ld=%b inc=%b expected 0 1", pc_load, pc_inc);
        end
        step();
        fetch_word(16'hA123);
        n_tests++;
        if (pc_load !== 1'b1 || pc_inc !== 1'b0 || pc_target !== 16'h0123) begin
            n_fail++;
            $display("FAIL jmp: ld=%b inc=%b tgt=%h expected 1 0 0123", pc_load, pc_inc, pc_target);
        end
        step();
    endtask

    task automatic test_loop();
        logic [11:0] exp_cnt [4];
        logic        exp_ld  [4];
        exp_cnt = '{12'h002, 12'h001, 12'h000, 12'hFFF};
        exp_ld  = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        go_start();
        fetch_word(16'hC003);
        n_tests++;
        if (pc_inc !== 1'b1 || pc_load !== 1'b0 || loop_cnt !== 12'h000) begin
            n_fail++;
            $display("FAIL ldc_decode: inc=%b ld=%b loop=%h expected 1 0 000", pc_inc, pc_load, loop_cnt);
        end
        step();
        n_tests++;
        if (loop_cnt !== 12'h003) begin
            n_fail++;
            $display("FAIL ldc_value: loop=%h expected 003", loop_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            fetch_word(16'hD005);
            n_tests++;
            if (pc_load !== exp_ld[i] || pc_inc !== ~exp_ld[i] || pc_target !== 16'h0005) begin
                n_fail++;
                $display("FAIL djnz_decode[%0d]: ld=%b inc=%b tgt=%h expected ld=%b inc=%b tgt=0005",
                         i, pc_load, pc_inc, pc_target, exp_ld[i], ~exp_ld[i]);
            end
            step();
            n_tests++;
            if (loop_cnt !== exp_cnt[i] || state !== 3'd1) begin
                n_fail++;
                $display("FAIL djnz_count[%0d]: loop=%h state=%0d expected %h 1", i, loop_cnt, state, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_stalls();
        int req_cnt;
        int es_cnt;
        req_cnt = 0;
        es_cnt  = 0;
        do_reset();
        go_start();
        instr      = 16'h1234;
        imem_ready = 1'b0;
        exec_done  = 1'b1;            // spurious, must be ignored in FETCH
        for (int i = 0; i < 4; i++) begin
            if (imem_req === 1'b1) req_cnt++;
            n_tests++;
            if (state !== 3'd1 || ir !== 16'h0000 || pc_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_wait[%0d]: state=%0d ir=%h inc=%b expected 1 0000 0", i, state, ir, pc_inc);
            end
            step();
        end
        exec_done  = 1'b0;
        imem_ready = 1'b1;
        #1;
        if (imem_req === 1'b1) req_cnt++;
        step();
        imem_ready = 1'b0;
        if (imem_req === 1'b1) req_cnt++;
        n_tests++;
        if (req_cnt != 5 || ir !== 16'h1234 || state !== 3'd2) begin
            n_fail++;
            $display("FAIL fetch_stall: req_cycles=%0d ir=%h state=%0d expected 5 1234 2", req_cnt, ir, state);
        end
        step();                       // first EXEC cycle
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (state !== 3'd3 || exec_start !== (i == 0) || pc_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL exec_wait[%0d]: state=%0d es=%b inc=%b expected 3 %b 0", i, state, exec_start, pc_inc, (i == 0));
            end
            if (exec_start === 1'b1) es_cnt++;
            step();
        end
        exec_done = 1'b1;
        #1;
        n_tests++;
        if (exec_start !== 1'b0 || pc_inc !== 1'b1 || pc_load !== 1'b0 || es_cnt != 1) begin
            n_fail++;
            $display("FAIL exec_done: es=%b inc=%b ld=%b pulses=%0d expected 0 1 0 1", exec_start, pc_inc, pc_load, es_cnt);
        end
        step();
        exec_done = 1'b0;
        n_tests++;
        if (state !== 3'd1 || pc_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_to_fetch: state=%0d inc=%b expected 1 0", state, pc_inc);
        end
    endtask

    task automatic test_async_reset();
        // Continues in FETCH from the previous task.
        fetch_word(16'hC007);
        step();
        fetch_word(16'h2000);
        step();
        exec_done = 1'b0;
        n_tests++;
        if (state !== 3'd3 || exec_start !== 1'b1 || loop_cnt !== 12'h007) begin
            n_fail++;
            $display("FAIL pre_reset_exec: state=%0d es=%b loop=%h expected 3 1 007", state, exec_start, loop_cnt);
        end
        #1;
        exec_done = 1'b1;
        Reset     = 1'b1;
        #1;
        n_tests++;
        if (state !== 3'd0 || loop_cnt !== 12'h0 || ir !== 16'h0 || exec_start !== 1'b0 ||
            pc_inc !== 1'b0 || pc_load !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0 || pc_target !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d loop=%h ir=%h es=%b inc=%b ld=%b req=%b h=%b tgt=%h expected all zero",
                     state, loop_cnt, ir, exec_start, pc_inc, pc_load, imem_req, halted, pc_target);
        end
        step();
        Reset = 1'b0;
        step();
        exec_done = 1'b0;
        n_tests++;
        if (state !== 3'd0 || pc_inc !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: state=%0d inc=%b req=%b expected 0 0 0", state, pc_inc, imem_req);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_program();
        test_jz();
        test_loop();
        test_stalls();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
